// File: rtl/bit_reverse_frame_buffer_if.sv
// Valid/ready frame stream carrying one N_SAMPLES x BIT_WIDTH frame per transfer.
// The master drives msg/val, the slave answers with rdy.
interface bit_reverse_frame_buffer_if #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
);
    logic [BIT_WIDTH-1:0] msg [N_SAMPLES-1:0];
    logic                 val;
    logic                 rdy;

    modport master (output msg, output val, input rdy);
    modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/bit_reverse_frame_buffer.sv
// Two-entry FIFO of frames, stored in bit-reversed sample order, sitting between
// the deserializer and the FFT so each side's back-pressure is decoupled.
module bit_reverse_frame_buffer #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic clk,
    input  logic reset,
    bit_reverse_frame_buffer_if.slave  recv,
    bit_reverse_frame_buffer_if.master send
);
    localparam int IDX_W = $clog2(N_SAMPLES);

    logic [BIT_WIDTH-1:0] slot [2][N_SAMPLES];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 recv_fire;
    logic                 send_fire;

    function automatic logic [IDX_W-1:0] rev(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] r;
        for (int k = 0; k < IDX_W; k++) begin
            r[k] = idx[IDX_W-1-k];
        end
        return r;
    endfunction

    // Flow control depends on occupancy alone, so there is no path from send.rdy to recv.rdy.
    assign recv.rdy  = (count != 2'd2);
    assign send.val  = (count != 2'd0);
    assign recv_fire = recv.val & recv.rdy;
    assign send_fire = send.val & send.rdy;

    always_comb begin
        for (int i = 0; i < N_SAMPLES; i++) begin
            send.msg[i] = slot[rd_ptr][i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            // NOTE: the slots are cleared on reset because send.msg must read all zeros
            // immediately afterwards; a pure datapath RAM would normally be left unreset.
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < N_SAMPLES; i++) begin
                    slot[s][i] <= '0;
                end
            end
        end else begin
            // NOTE: non-blocking assignments keep every register update tied to the
            // pre-edge values, so read and write of the same slot in one cycle are safe.
            if (recv_fire) begin
                for (int i = 0; i < N_SAMPLES; i++) begin
                    slot[wr_ptr][rev(IDX_W'(i))] <= recv.msg[i];
                end
                wr_ptr <= ~wr_ptr;
            end
            if (send_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({recv_fire, send_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_bit_reverse_frame_buffer.sv
// Self-checking bench: directed vector table, hand-written throughput/reset sequences,
// and randomized traffic checked against a queue-based model of the buffer.
module tb_bit_reverse_frame_buffer;
    localparam int W   = 32;
    localparam int N   = 8;
    localparam int LOG = $clog2(N);
    localparam int FW  = W * N;

    typedef logic [N-1:0][W-1:0] frame_t;

    typedef struct {
        logic rv;
        int   msg_id;
        logic sr;
        logic exp_rdy;
        logic exp_val;
        int   exp_id;   // -1: send_msg is don't-care this cycle
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    frame_t q[$];
    bit     zero_exp;
    frame_t fr [5];
    frame_t ex [5];
    vec_t   vecs [9];

    bit_reverse_frame_buffer_if #(.BIT_WIDTH(W), .N_SAMPLES(N)) recv_if ();
    bit_reverse_frame_buffer_if #(.BIT_WIDTH(W), .N_SAMPLES(N)) send_if ();

    bit_reverse_frame_buffer #(.BIT_WIDTH(W), .N_SAMPLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .recv  (recv_if),
        .send  (send_if)
    );

    always #5 clk = ~clk;

    function automatic int rev_idx(input int i);
        int r = 0;
        for (int k = 0; k < LOG; k++) begin
            r = r * 2 + ((i >> k) & 1);
        end
        return r;
    endfunction

    function automatic frame_t rev_frame(input frame_t f);
        frame_t r;
        for (int j = 0; j < N; j++) begin
            r[j] = f[rev_idx(j)];
        end
        return r;
    endfunction

    function automatic frame_t get_send();
        frame_t f;
        for (int j = 0; j < N; j++) begin
            f[j] = send_if.msg[j];
        end
        return f;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int j = 0; j < N; j++) begin
            f[j] = $urandom;
        end
        return f;
    endfunction

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input frame_t m, input logic sr);
        recv_if.val = rv;
        for (int i = 0; i < N; i++) begin
            recv_if.msg[i] = m[i];
        end
        send_if.rdy = sr;
    endtask

    task automatic check_model();
        check("recv_rdy", FW'(recv_if.rdy), FW'(q.size() < 2));
        check("send_val", FW'(send_if.val), FW'(q.size() > 0));
        if (q.size() > 0) begin
            check("send_msg", get_send(), rev_frame(q[0]));
        end else if (zero_exp) begin
            check("send_msg_zero", get_send(), '0);
        end
    endtask

    // Called at the negedge with inputs stable; commits the model at the next posedge.
    task automatic advance();
        bit     rfire;
        bit     sfire;
        frame_t m;
        rfire = recv_if.val && (q.size() < 2);
        sfire = send_if.rdy && (q.size() > 0);
        for (int i = 0; i < N; i++) begin
            m[i] = recv_if.msg[i];
        end
        @(posedge clk);
        if (reset) begin
            q.delete();
            zero_exp = 1'b1;
        end else begin
            if (sfire) void'(q.pop_front());
            if (rfire) begin
                q.push_back(m);
                zero_exp = 1'b0;
            end
        end
        #1;
    endtask

    task automatic step_model(input logic rv, input frame_t m, input logic sr);
        drive(rv, m, sr);
        @(negedge clk);
        check_model();
        advance();
    endtask

    initial begin
        int lit [N];
        lit = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int j = 0; j < N; j++) begin
            fr[0][j] = '0;
            fr[1][j] = W'(j);
            fr[2][j] = 32'hA000_0000 + W'(j);
            fr[3][j] = 32'hB000_0000 + W'(j);
            fr[4][j] = 32'hC000_0000 + W'(j);
            ex[1][j] = W'(lit[j]);
        end
        ex[0] = '0;
        ex[2] = rev_frame(fr[2]);
        ex[3] = rev_frame(fr[3]);
        ex[4] = rev_frame(fr[4]);

        vecs[0] = '{1'b1, 1, 1'b1, 1'b1, 1'b0,  0};
        vecs[1] = '{1'b0, 0, 1'b1, 1'b1, 1'b1,  1};
        vecs[2] = '{1'b1, 2, 1'b0, 1'b1, 1'b0, -1};
        vecs[3] = '{1'b1, 3, 1'b0, 1'b1, 1'b1,  2};
        vecs[4] = '{1'b1, 4, 1'b0, 1'b0, 1'b1,  2};
        vecs[5] = '{1'b1, 4, 1'b1, 1'b0, 1'b1,  2};
        vecs[6] = '{1'b1, 4, 1'b1, 1'b1, 1'b1,  3};
        vecs[7] = '{1'b0, 0, 1'b1, 1'b1, 1'b1,  4};
        vecs[8] = '{1'b0, 0, 1'b0, 1'b1, 1'b0, -1};

        zero_exp = 1'b1;
        reset    = 1'b1;
        drive(1'b0, fr[0], 1'b0);
        repeat (2) begin
            @(negedge clk);
            advance();
        end
        reset = 1'b0;

        // Directed table: reset state, reorder, back-pressure, full + simultaneous.
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].rv, fr[vecs[v].msg_id], vecs[v].sr);
            @(negedge clk);
            check($sformatf("vec%0d_recv_rdy", v), FW'(recv_if.rdy), FW'(vecs[v].exp_rdy));
            check($sformatf("vec%0d_send_val", v), FW'(send_if.val), FW'(vecs[v].exp_val));
            if (vecs[v].exp_id >= 0) begin
                check($sformatf("vec%0d_send_msg", v), get_send(), ex[vecs[v].exp_id]);
            end
            advance();
        end

        // Full throughput: 16 distinct frames back to back, one in and one out per cycle.
        for (int f = 0; f < 16; f++) begin
            frame_t m;
            for (int j = 0; j < N; j++) begin
                m[j] = W'(f * 256 + j);
            end
            step_model(1'b1, m, 1'b1);
            if (f > 0) check("thru_count_one", FW'(q.size()), FW'(1));
        end
        step_model(1'b0, fr[0], 1'b1);
        step_model(1'b0, fr[0], 1'b1);

        // Reset with two frames buffered: nothing old may leak out afterwards.
        step_model(1'b1, rand_frame(), 1'b0);
        step_model(1'b1, rand_frame(), 1'b0);
        reset = 1'b1;
        step_model(1'b1, rand_frame(), 1'b1);
        reset = 1'b0;
        step_model(1'b1, fr[2], 1'b0);
        step_model(1'b0, fr[0], 1'b1);
        step_model(1'b0, fr[0], 1'b1);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            step_model($urandom_range(0, 3) != 0, rand_frame(), $urandom_range(0, 2) != 0);
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
